// File: rtl/ga_dram_slot_scheduler.sv
// Gate-array memory slot scheduler: splits each microsecond into a video slot and a CPU slot.
// It drives the DRAM/ROM strobes and the Z80 READY handshake. Define GA_RFSH_COUNTER_EN to build the refresh row counter.
module ga_dram_slot_scheduler #(
    parameter int unsigned READY_PHASE = 12,
    parameter logic [1:0]  LOROM_TOP   = 2'b00,
    parameter logic [1:0]  HIROM_TOP   = 2'b11
) (
    input  logic       ck16,
    input  logic       reset,
    input  logic       a15,
    input  logic       a14,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       lorom_en,
    input  logic       hirom_en,
    output logic [3:0] phase,
    output logic       phi_n,
    output logic       cclk,
    output logic       ready,
    output logic       ras_n,
    output logic       cas_n,
    output logic       casad_n,
    output logic       mwe_n,
    output logic       ramrd_n,
    output logic       romen_n,
    output logic       cpu_n,
    output logic       vid_latch,
    output logic       vid_byte,
    output logic [6:0] rfsh_addr
);

    typedef enum logic [1:0] {IDLE, WAIT, GRANT, DONE} state_t;

    localparam logic [3:0] READY_PH = 4'(READY_PHASE);

    state_t     state;
    state_t     state_next;
    logic [3:0] phase_next;
    logic       mem_req;
    logic       io_req;
    logic       any_req;
    logic       req_write;
    logic       req_io;
    logic       req_rom;
    logic       take;
    logic       kind_write;
    logic       kind_io;
    logic       kind_rom;
    logic       write_next;
    logic       io_next;
    logic       rom_next;
    logic       ram_acc;
    logic       ready_d;
    logic       ras_d;
    logic       cas_d;
    logic       casad_d;
    logic       mwe_d;
    logic       ramrd_d;
    logic       romen_d;
    logic       cpu_d;
    logic       vid_ras;
    logic       vid_cas;

    function automatic logic in_range(input logic [3:0] p, input logic [3:0] lo,
                                      input logic [3:0] hi);
        return (p >= lo) && (p <= hi);
    endfunction

    // Outputs are registered, so everything is decoded for the phase about to start.
    always_comb begin
        phase_next = phase + 4'd1;
        mem_req    = !mreq_n && (!rd_n || !wr_n);
        // An interrupt acknowledge is treated as an ordinary IO cycle.
        io_req     = !iorq_n || (!m1_n && !iorq_n);
        any_req    = mem_req || io_req;
        req_write  = mem_req && !wr_n;
        req_io     = !mem_req;
        req_rom    = mem_req && wr_n &&
                     ((lorom_en && ({a15, a14} == LOROM_TOP)) ||
                      (hirom_en && ({a15, a14} == HIROM_TOP)));

        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = (phase == 4'd8) ? GRANT : WAIT;
            WAIT: begin
                if (!any_req)             state_next = IDLE;
                else if (phase == 4'd8)   state_next = GRANT;
            end
            GRANT:   if (phase == 4'd15) state_next = DONE;
            DONE:    if (mreq_n && iorq_n) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        take       = (state != GRANT) && (state_next == GRANT);
        write_next = take ? req_write : kind_write;
        io_next    = take ? req_io    : kind_io;
        rom_next   = take ? req_rom   : kind_rom;
        ram_acc    = (state_next == GRANT) && !io_next && !rom_next;

        case (state_next)
            WAIT:    ready_d = 1'b0;
            GRANT:   ready_d = (phase_next >= READY_PH);
            default: ready_d = 1'b1;
        endcase

        vid_ras = in_range(phase_next, 4'd1, 4'd3) || in_range(phase_next, 4'd5, 4'd7);
        vid_cas = in_range(phase_next, 4'd2, 4'd3) || in_range(phase_next, 4'd6, 4'd7);

        // Slots without a RAM access still run a short RAS-only refresh.
        ras_d   = vid_ras ||
                  (ram_acc  && in_range(phase_next, 4'd9, 4'd13)) ||
                  (!ram_acc && in_range(phase_next, 4'd9, 4'd11));
        casad_d = vid_cas || (ram_acc && in_range(phase_next, 4'd10, 4'd13));
        cas_d   = vid_cas || (ram_acc && in_range(phase_next, 4'd11, 4'd13));
        mwe_d   = ram_acc && write_next && in_range(phase_next, 4'd11, 4'd13);
        ramrd_d = ram_acc && !write_next && in_range(phase_next, 4'd10, 4'd14);
        romen_d = (state_next == GRANT) && rom_next && in_range(phase_next, 4'd9, 4'd14);
        cpu_d   = (state_next == GRANT) && !io_next && in_range(phase_next, 4'd9, 4'd14);
    end

    always_ff @(posedge ck16) begin
        if (reset) begin
            phase      <= 4'd0;
            state      <= IDLE;
            kind_write <= 1'b0;
            kind_io    <= 1'b0;
            kind_rom   <= 1'b0;
            ready      <= 1'b1;
            phi_n      <= 1'b1;
            cclk       <= 1'b0;
            ras_n      <= 1'b1;
            cas_n      <= 1'b1;
            casad_n    <= 1'b1;
            mwe_n      <= 1'b1;
            ramrd_n    <= 1'b1;
            romen_n    <= 1'b1;
            cpu_n      <= 1'b1;
            vid_latch  <= 1'b0;
            vid_byte   <= 1'b0;
        end else begin
            phase      <= phase_next;
            state      <= state_next;
            kind_write <= write_next;
            kind_io    <= io_next;
            kind_rom   <= rom_next;
            ready      <= ready_d;
            phi_n      <= !phase_next[1];
            cclk       <= phase_next[3];
            ras_n      <= !ras_d;
            cas_n      <= !cas_d;
            casad_n    <= !casad_d;
            mwe_n      <= !mwe_d;
            ramrd_n    <= !ramrd_d;
            romen_n    <= !romen_d;
            cpu_n      <= !cpu_d;
            vid_latch  <= (phase_next == 4'd3) || (phase_next == 4'd7);
            if ((phase_next == 4'd3) || (phase_next == 4'd7)) begin
                vid_byte <= phase_next[2];
            end
        end
    end

`ifdef GA_RFSH_COUNTER_EN
    // Advance the refresh row once per slot that ran a refresh cycle.
    always_ff @(posedge ck16) begin
        if (reset) begin
            rfsh_addr <= 7'd0;
        end else if ((phase_next == 4'd12) && !ram_acc) begin
            rfsh_addr <= rfsh_addr + 7'd1;
        end
    end
`else
    assign rfsh_addr = 7'd0;
`endif

endmodule

// File: tb/tb_ga_dram_slot_scheduler.sv
// Scoreboard bench for ga_dram_slot_scheduler: expected per-phase outputs are queued as inputs are driven.
// Each queued entry is compared one edge later.
module tb_ga_dram_slot_scheduler;

    localparam int READY = 12;
    localparam int CLS_NONE = 0;
    localparam int CLS_RD   = 1;
    localparam int CLS_WR   = 2;
    localparam int CLS_ROM  = 3;
    localparam int CLS_IO   = 4;

    typedef struct packed {
        logic rst;
        logic a15;
        logic a14;
        logic mreq_n;
        logic iorq_n;
        logic m1_n;
        logic rd_n;
        logic wr_n;
        logic lorom_en;
        logic hirom_en;
    } stim_t;

    typedef struct {
        logic [3:0] phase;
        logic       ready;
        logic       phi_n;
        logic       cclk;
        logic       vid_latch;
        logic       vid_byte;
        logic       chk_vb;
        logic       ras_n;
        logic       casad_n;
        logic       cas_n;
        logic       mwe_n;
        logic       ramrd_n;
        logic       romen_n;
        logic       cpu_n;
        logic [6:0] rfsh;
        logic       chk_rf;
    } exp_t;

    logic       ck16;
    logic       reset;
    logic       a15, a14, mreq_n, iorq_n, m1_n, rd_n, wr_n, lorom_en, hirom_en;
    logic [3:0] phase;
    logic       phi_n, cclk, ready, ras_n, cas_n, casad_n, mwe_n, ramrd_n, romen_n, cpu_n;
    logic       vid_latch, vid_byte;
    logic [6:0] rfsh_addr;

    exp_t       expQ[$];
    int         tbPhase;
    logic [6:0] expRfsh;
    int         checkCount;
    int         errorCount;

    ga_dram_slot_scheduler #(
        .READY_PHASE(READY),
        .LOROM_TOP  (2'b00),
        .HIROM_TOP  (2'b11)
    ) dut (
        .ck16     (ck16),
        .reset    (reset),
        .a15      (a15),
        .a14      (a14),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .m1_n     (m1_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .lorom_en (lorom_en),
        .hirom_en (hirom_en),
        .phase    (phase),
        .phi_n    (phi_n),
        .cclk     (cclk),
        .ready    (ready),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .casad_n  (casad_n),
        .mwe_n    (mwe_n),
        .ramrd_n  (ramrd_n),
        .romen_n  (romen_n),
        .cpu_n    (cpu_n),
        .vid_latch(vid_latch),
        .vid_byte (vid_byte),
        .rfsh_addr(rfsh_addr)
    );

    initial ck16 = 1'b0;
    always #5 ck16 = ~ck16;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic inR(input int p, input int lo, input int hi);
        return (p >= lo) && (p <= hi);
    endfunction

    // Expected outputs for one phase, taken from the slot timing tables.
    function automatic exp_t expectAt(input int ph, input int cls, input bit rdy,
                                      input logic [6:0] rf);
        exp_t e;
        e.phase     = 4'(ph);
        e.ready     = rdy;
        e.phi_n     = ((ph / 2) % 2 == 0);
        e.cclk      = (ph >= 8);
        e.vid_latch = (ph == 3) || (ph == 7);
        e.vid_byte  = (ph == 7);
        e.chk_vb    = e.vid_latch;
        e.rfsh      = rf;
        e.chk_rf    = (ph == 0);
        e.ras_n = 1; e.casad_n = 1; e.cas_n = 1; e.mwe_n = 1;
        e.ramrd_n = 1; e.romen_n = 1; e.cpu_n = 1;
        if (ph < 8) begin
            e.ras_n   = !(inR(ph, 1, 3) || inR(ph, 5, 7));
            e.casad_n = !(inR(ph, 2, 3) || inR(ph, 6, 7));
            e.cas_n   = e.casad_n;
        end else if (cls == CLS_RD || cls == CLS_WR) begin
            e.ras_n   = !inR(ph, 9, 13);
            e.casad_n = !inR(ph, 10, 13);
            e.cas_n   = !inR(ph, 11, 13);
            e.cpu_n   = !inR(ph, 9, 14);
            if (cls == CLS_RD) e.ramrd_n = !inR(ph, 10, 14);
            else               e.mwe_n   = !inR(ph, 11, 13);
        end else begin
            e.ras_n = !inR(ph, 9, 11);
            if (cls == CLS_ROM) begin
                e.romen_n = !inR(ph, 9, 14);
                e.cpu_n   = !inR(ph, 9, 14);
            end
        end
        return e;
    endfunction

    function automatic stim_t mkStim(input bit rst, input bit mq, input bit iq, input bit m1,
                                     input bit rd, input bit wr, input bit [1:0] a,
                                     input bit lo, input bit hi);
        stim_t s;
        s.rst = rst; s.mreq_n = mq; s.iorq_n = iq; s.m1_n = m1; s.rd_n = rd; s.wr_n = wr;
        s.a15 = a[1]; s.a14 = a[0]; s.lorom_en = lo; s.hirom_en = hi;
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the next phase must look like.
    task automatic applyStimulus(input stim_t s, input int cls, input bit rdy);
        int   nxt;
        exp_t e;
        @(negedge ck16);
        reset = s.rst; a15 = s.a15; a14 = s.a14; mreq_n = s.mreq_n; iorq_n = s.iorq_n;
        m1_n = s.m1_n; rd_n = s.rd_n; wr_n = s.wr_n; lorom_en = s.lorom_en; hirom_en = s.hirom_en;
        if (s.rst) begin
            nxt      = 0;
            expRfsh  = 7'd0;
            e        = expectAt(0, CLS_NONE, 1'b1, 7'd0);
            e.chk_vb = 1'b1;
        end else begin
            nxt = (tbPhase + 1) % 16;
`ifdef GA_RFSH_COUNTER_EN
            if (nxt == 12 && cls != CLS_RD && cls != CLS_WR) expRfsh = expRfsh + 7'd1;
`endif
            e = expectAt(nxt, cls, rdy, expRfsh);
        end
        expQ.push_back(e);
        tbPhase = nxt;
    endtask

    stim_t idleS;

    task automatic idleUntil(input int p);
        while (tbPhase != p) applyStimulus(idleS, CLS_NONE, 1'b1);
    endtask

    // Hold a request from phase 'start' through its granted slot, optionally keep holding, then release.
    task automatic runRequest(input stim_t req, input int cls, input int start, input int hold);
        int nxt;
        bit rdy;
        idleUntil(start);
        for (int k = start; k < 16; k++) begin
            nxt = (k + 1) % 16;
            rdy = (nxt == 0) ? 1'b1 : ((nxt >= 9) ? (nxt >= READY) : 1'b0);
            applyStimulus(req, cls, rdy);
        end
        for (int k = 0; k < hold; k++) applyStimulus(req, CLS_NONE, 1'b1);
        applyStimulus(idleS, CLS_NONE, 1'b1);
    endtask

    always @(posedge ck16) begin : monitor
        exp_t e;
        #1;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("phase@%0d", e.phase), 32'(phase), 32'(e.phase));
            checkOutput($sformatf("ready@%0d", e.phase), 32'(ready), 32'(e.ready));
            checkOutput($sformatf("clocks@%0d", e.phase), {29'd0, phi_n, cclk, vid_latch},
                        {29'd0, e.phi_n, e.cclk, e.vid_latch});
            checkOutput($sformatf("strobes@%0d", e.phase),
                        {25'd0, ras_n, casad_n, cas_n, mwe_n, ramrd_n, romen_n, cpu_n},
                        {25'd0, e.ras_n, e.casad_n, e.cas_n, e.mwe_n, e.ramrd_n, e.romen_n, e.cpu_n});
            if (e.chk_vb) checkOutput($sformatf("vid_byte@%0d", e.phase), 32'(vid_byte), 32'(e.vid_byte));
            if (e.chk_rf) checkOutput("rfsh_addr", 32'(rfsh_addr), 32'(e.rfsh));
        end
    end

    initial begin
        stim_t s;
        checkCount = 0;
        errorCount = 0;
        tbPhase    = 0;
        expRfsh    = 7'd0;
        idleS      = mkStim(0, 1, 1, 1, 1, 1, 2'b00, 0, 0);
        reset = 1; a15 = 0; a14 = 0; mreq_n = 1; iorq_n = 1; m1_n = 1; rd_n = 1; wr_n = 1;
        lorom_en = 0; hirom_en = 0;

        s = idleS; s.rst = 1'b1;
        repeat (3) applyStimulus(s, CLS_NONE, 1'b1);
        repeat (32) applyStimulus(idleS, CLS_NONE, 1'b1);

        $display("[TB] RAM read from WAIT");
        runRequest(mkStim(0, 0, 1, 1, 0, 1, 2'b01, 0, 0), CLS_RD, 2, 0);

        $display("[TB] write granted at phase 8, held one more slot");
        runRequest(mkStim(0, 0, 1, 1, 1, 0, 2'b01, 0, 0), CLS_WR, 8, 16);

        $display("[TB] ROM and RAM reads at 11, lower ROM, write under ROM");
        runRequest(mkStim(0, 0, 1, 1, 0, 1, 2'b11, 0, 1), CLS_ROM, 4, 0);
        runRequest(mkStim(0, 0, 1, 1, 0, 1, 2'b11, 0, 0), CLS_RD, 4, 0);
        runRequest(mkStim(0, 0, 1, 1, 0, 1, 2'b00, 1, 0), CLS_ROM, 6, 0);
        runRequest(mkStim(0, 0, 1, 1, 1, 0, 2'b00, 1, 1), CLS_WR, 5, 0);

        $display("[TB] IO and interrupt acknowledge");
        runRequest(mkStim(0, 1, 0, 1, 0, 1, 2'b00, 0, 0), CLS_IO, 5, 0);
        runRequest(mkStim(0, 1, 0, 0, 1, 1, 2'b00, 0, 0), CLS_IO, 8, 0);

        $display("[TB] request dropped while waiting");
        idleUntil(3);
        applyStimulus(mkStim(0, 0, 1, 1, 0, 1, 2'b01, 0, 0), CLS_NONE, 1'b0);
        applyStimulus(mkStim(0, 0, 1, 1, 0, 1, 2'b01, 0, 0), CLS_NONE, 1'b0);
        applyStimulus(idleS, CLS_NONE, 1'b1);

        $display("[TB] reset in the middle of a write");
        idleUntil(8);
        repeat (3) applyStimulus(mkStim(0, 0, 1, 1, 1, 0, 2'b01, 0, 0), CLS_WR, 1'b0);
        s = mkStim(1, 0, 1, 1, 1, 0, 2'b01, 0, 0);
        applyStimulus(s, CLS_NONE, 1'b1);
        applyStimulus(idleS, CLS_NONE, 1'b1);

        $display("[TB] refresh counter over a full wrap");
        repeat (130 * 16) applyStimulus(idleS, CLS_NONE, 1'b1);

        @(posedge ck16);
        @(posedge ck16);
        #2;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
